hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage MIPS core; successor to the combinational hazard detector.
//  Decides PC hold, IF/ID hold/flush and ID/EX bubble from ID source regs vs EX/MEM producers, with or without forwarding.
//  Adds a multi-cycle mul/div busy tracker, a saturating stall-cycle counter and a sticky stall-timeout error.
//  Sits between the ID decode logic and the pipeline-register enables; the branch decision (PCSrc) comes from EX.
// PARAMETERS
//  REG_W         5   register-specifier width
//  FWD_EN        1   1: forwarding present, stall only on load-use; 0: stall on any EX/MEM producer
//  MD_LATENCY    32  mul/div occupancy in cycles after issue; 0 disables busy tracking
//  CNT_W         32  width of Stall_Count
//  STALL_TIMEOUT 64  consecutive stall cycles that raise Hazard_Err
// PORTS
//  Clk           in   1      clock, rising edge
//  Reset         in   1      asynchronous, active-high
//  PCSrc         in   1      branch/jump taken, resolved in EX
//  ID_Rs, ID_Rt  in   REG_W  ID source specifiers
//  ID_UsesRs/Rt  in   1      ID instruction actually reads Rs / Rt
//  ID_IsMD       in   1      ID holds mult/multu/div/divu
//  ID_ReadsHiLo  in   1      ID holds mfhi/mflo
//  EX_Rd, MEM_Rd in   REG_W  destination specifiers
//  EX_RegWrite, MEM_RegWrite  in 1  destination written
//  EX_MemRead    in   1      EX holds a load
//  PC_Write      out  1      1: PC updates
//  IF_ID_Ctrl    out  2      0 normal, 1 hold, 2 flush (3 unused)
//  ID_EX_Bubble  out  1      1: ID/EX loads a nop
//  MD_Busy       out  1      mul/div unit occupied
//  Stall_Count   out  CNT_W  saturating count of stall cycles
//  Hazard_Err    out  1      sticky stall-timeout flag
// BEHAVIOUR
//  dep(X) = X_RegWrite && X_Rd!=0 && ((ID_UsesRs && ID_Rs==X_Rd) || (ID_UsesRt && ID_Rt==X_Rd)).
//  WB is never a hazard: the register file writes in the first half-cycle.
//  data_stall = FWD_EN ? (dep(EX) && EX_MemRead) : (dep(EX) || dep(MEM)).
//  md_stall   = MD_Busy && (ID_IsMD || ID_ReadsHiLo).
//  stall      = !PCSrc && (data_stall || md_stall).
//  Priority per cycle (combinational outputs):
//    1. PCSrc=1 (flush): PC_Write=1, IF_ID_Ctrl=2, ID_EX_Bubble=1.
//    2. stall: PC_Write=0, IF_ID_Ctrl=1, ID_EX_Bubble=1.
//    3. otherwise: PC_Write=1, IF_ID_Ctrl=0, ID_EX_Bubble=0.
//  MD tracker: md_cnt (width clog2(MD_LATENCY+1)); MD_Busy = (md_cnt!=0).
//    issue = ID_IsMD && !stall && !PCSrc.
//    On the issue edge, md_cnt <= MD_LATENCY; else if md_cnt!=0, md_cnt <= md_cnt-1.
//    No issue can occur while busy; an MD in ID with md_cnt==1 stalls once, then issues.
//  Stall counter: +1 on each stall cycle, saturating at all-ones; flush cycles are not counted.
//  Timeout: run_len counts consecutive stall cycles, cleared on any non-stall cycle.
//    When run_len reaches STALL_TIMEOUT, Hazard_Err <= 1 and holds until Reset.
//  Reset (async, overrides everything):
//    registers: md_cnt=0, run_len=0, Stall_Count=0, Hazard_Err=0.
//    outputs while Reset high: PC_Write=0, IF_ID_Ctrl=2, ID_EX_Bubble=1, MD_Busy=0.
//    Reset mid-MD discards occupancy; a reset-mid-stall run does not carry over.
//  Rd==0 never creates a dependency; X on unused-source specifiers is ignored via ID_UsesRs/Rt.
// TESTING
//  T1: FWD_EN=1, EX lw $8, ID add $9,$8,$1 -> 1 cycle PC_Write=0, IF_ID_Ctrl=1, ID_EX_Bubble=1; then normal; Stall_Count=1.
//  T2: FWD_EN=0, MEM_RegWrite, MEM_Rd=5, ID_Rt=5, ID_UsesRt=1 -> stall; EX_Rd=0 with ID_Rs=0 -> no stall.
//  T3: PCSrc=1 together with a load-use dependency -> IF_ID_Ctrl=2, PC_Write=1, Stall_Count unchanged.
//  T4: MD_LATENCY=4, issue mult, then mflo held in ID -> MD_Busy for 4 cycles, mflo stalls 4 cycles, issues on cycle 5.
//  T5: STALL_TIMEOUT=64, hold a dependency for 64 cycles -> Hazard_Err=1 after cycle 64, still 1 after the hazard clears.
//  T6: assert Reset mid-MD (md_cnt=3) -> MD_Busy=0, Stall_Count=0, Hazard_Err=0 immediately; outputs show flush while Reset is high.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use / producer stalls, branch flush, mul/div busy
// tracking, saturating stall counter and sticky stall-timeout error.
module hazard_ctrl_unit #(
  parameter int REG_W         = 5,
  parameter int FWD_EN        = 1,
  parameter int MD_LATENCY    = 32,
  parameter int CNT_W         = 32,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCSrc,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_IsMD,
  input  logic             ID_ReadsHiLo,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic [REG_W-1:0] MEM_Rd,
  input  logic             EX_RegWrite,
  input  logic             MEM_RegWrite,
  input  logic             EX_MemRead,
  output logic             PC_Write,
  output logic [1:0]       IF_ID_Ctrl,
  output logic             ID_EX_Bubble,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_Count,
  output logic             Hazard_Err
);

  localparam int MD_W     = (MD_LATENCY > 0) ? $clog2(MD_LATENCY + 1) : 1;
  localparam int RUN_W    = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [MD_W-1:0]  MD_LOAD  = MD_W'(MD_LATENCY);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IFID_NORMAL = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_FLUSH  = 2'd2
  } ifid_ctrl_e;

  logic [MD_W-1:0]  r_md_cnt;
  logic [RUN_W-1:0] r_run_len;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err;

  logic w_dep_ex, w_dep_mem, w_data_stall, w_md_busy, w_md_stall, w_stall, w_issue;

  assign w_dep_ex  = EX_RegWrite && (EX_Rd != '0) &&
                     ((ID_UsesRs && (ID_Rs == EX_Rd)) || (ID_UsesRt && (ID_Rt == EX_Rd)));
  assign w_dep_mem = MEM_RegWrite && (MEM_Rd != '0) &&
                     ((ID_UsesRs && (ID_Rs == MEM_Rd)) || (ID_UsesRt && (ID_Rt == MEM_Rd)));

  // With forwarding only a load in EX cannot be bypassed in time.
  assign w_data_stall = (FWD_EN != 0) ? (w_dep_ex && EX_MemRead) : (w_dep_ex || w_dep_mem);
  assign w_md_busy    = (r_md_cnt != '0);
  assign w_md_stall   = w_md_busy && (ID_IsMD || ID_ReadsHiLo);
  assign w_stall      = !PCSrc && (w_data_stall || w_md_stall);
  assign w_issue      = ID_IsMD && !w_stall && !PCSrc;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Ctrl   = IFID_NORMAL;
    ID_EX_Bubble = 1'b0;
    if (Reset) begin
      PC_Write     = 1'b0;
      IF_ID_Ctrl   = IFID_FLUSH;
      ID_EX_Bubble = 1'b1;
    end else if (PCSrc) begin
      IF_ID_Ctrl   = IFID_FLUSH;
      ID_EX_Bubble = 1'b1;
    end else if (w_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Ctrl   = IFID_HOLD;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_md_cnt    <= '0;
      r_run_len   <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_issue) begin
        r_md_cnt <= MD_LOAD;
      end else if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - MD_W'(1);
      end

      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      // Run length saturates at the timeout so it never wraps during a long stall.
      if (w_stall) begin
        if (r_run_len != RUN_MAX) begin
          r_run_len <= r_run_len + RUN_W'(1);
        end
        if (r_run_len >= RUN_TRIP) begin
          r_err <= 1'b1;
        end
      end else begin
        r_run_len <= '0;
      end
    end
  end

  assign MD_Busy     = w_md_busy;
  assign Stall_Count = r_stall_cnt;
  assign Hazard_Err  = r_err;

endmodule
